// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALUControl codes and execute-stage state encoding
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Number of operations held by the stage: none, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b10
  } stage_state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU: result, zero and illegal-code flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // Decode the operation; unlisted and unknown codes fall to the default arm,
  // which forces a clean all-zero result so X never reaches the registers.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_control)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

  // Zero is derived from the very result that will be stored alongside it.
  always_comb begin
    zero = (result == '0);
  end

endmodule

// File: rtl/exec_alu_stage.sv
// rtl/exec_alu_stage.sv - registered ALU execute stage with 2-entry skid buffer
module exec_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             illegal_op
);

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_illegal;

  stage_state_e     state_q, state_d;

  logic [WIDTH-1:0] main_result_q, main_result_d;
  logic             main_zero_q, main_zero_d;
  logic             main_illegal_q, main_illegal_d;

  logic [WIDTH-1:0] skid_result_q, skid_result_d;
  logic             skid_zero_q, skid_zero_d;
  logic             skid_illegal_q, skid_illegal_d;

  logic             accept;
  logic             transfer;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .result     (core_result),
    .zero       (core_zero),
    .illegal    (core_illegal)
  );

  // Handshake decode: ready depends only on the state register, so there is
  // no combinational path from out_ready back to in_ready.
  always_comb begin
    in_ready  = (state_q != SKID);
    out_valid = (state_q != EMPTY);
    accept    = in_valid & in_ready;
    transfer  = out_valid & out_ready;
  end

  // Next-state and register-load selection for main and skid entries.
  always_comb begin
    state_d        = state_q;
    main_result_d  = main_result_q;
    main_zero_d    = main_zero_q;
    main_illegal_d = main_illegal_q;
    skid_result_d  = skid_result_q;
    skid_zero_d    = skid_zero_q;
    skid_illegal_d = skid_illegal_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d        = FULL;
          main_result_d  = core_result;
          main_zero_d    = core_zero;
          main_illegal_d = core_illegal;
        end
      end
      FULL: begin
        if (accept && transfer) begin
          main_result_d  = core_result;
          main_zero_d    = core_zero;
          main_illegal_d = core_illegal;
        end else if (transfer) begin
          state_d = EMPTY;
        end else if (accept) begin
          // Downstream stalled: park the new op behind the one on display.
          state_d        = SKID;
          skid_result_d  = core_result;
          skid_zero_d    = core_zero;
          skid_illegal_d = core_illegal;
        end
      end
      SKID: begin
        if (transfer) begin
          state_d        = FULL;
          main_result_d  = skid_result_q;
          main_zero_d    = skid_zero_q;
          main_illegal_d = skid_illegal_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, main and skid registers; reset discards anything held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= EMPTY;
      main_result_q  <= '0;
      main_zero_q    <= 1'b0;
      main_illegal_q <= 1'b0;
      skid_result_q  <= '0;
      skid_zero_q    <= 1'b0;
      skid_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      main_result_q  <= main_result_d;
      main_zero_q    <= main_zero_d;
      main_illegal_q <= main_illegal_d;
      skid_result_q  <= skid_result_d;
      skid_zero_q    <= skid_zero_d;
      skid_illegal_q <= skid_illegal_d;
    end
  end

  // Outputs come straight from the main register.
  always_comb begin
    alu_result = main_result_q;
    zero       = main_zero_q;
    illegal_op = main_illegal_q;
  end

endmodule

// File: tb/tb_exec_alu_stage.sv
// tb/tb_exec_alu_stage.sv - scoreboard bench for exec_alu_stage
module tb_exec_alu_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_control;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_result;
  logic         zero;
  logic         illegal_op;

  always #5 clk = ~clk;

  exec_alu_stage #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         il;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  logic [2:0] x_probe;
  bit   four_state;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.il = 1'b0;
    case (c)
      3'b000:  e.r = a + b;
      3'b001:  e.r = a - b;
      3'b010:  e.r = a & b;
      3'b011:  e.r = a | b;
      3'b101:  e.r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: begin e.r = '0; e.il = 1'b1; end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Pop and compare every op that transfers on the coming rising edge.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(alu_result), 64'(mon_e.r));
        check("zero", 64'(zero), 64'(mon_e.z));
        check("illegal", 64'(illegal_op), 64'(mon_e.il));
        n_out++;
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    int  t = 0;
    bit  done = 1'b0;
    in_valid    = 1'b1;
    alu_control = c;
    src_a       = a;
    src_b       = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(c, a, b));
        done = 1'b1;
      end else if (++t > 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c0;
    x_probe     = 3'bxxx;
    four_state  = $isunknown(x_probe);
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_control = 3'b000;
    src_a       = '0;
    src_b       = '0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(alu_result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_illegal", 64'(illegal_op), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    send(3'b000, 5, 7);
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'd1);
    check("first_result", 64'(alu_result), 64'd12);
    @(posedge clk);
    #1;

    send(3'b001, 3, 3);
    send(3'b000, 32'hFFFF_FFFF, 1);
    send(3'b101, 32'hFFFF_FFFF, 1);
    send(3'b101, 1, 32'hFFFF_FFFF);
    send(3'b010, 32'h0000_F0F0, 32'h0000_0FF0);
    send(3'b011, 32'h0000_F000, 32'h0000_000F);
    send(3'b110, 9, 4);
    send(3'bxxx, 9, 4);
    @(negedge clk);
    if (four_state) begin
      check("x_illegal", 64'(illegal_op), 64'd1);
      check("x_result", 64'(alu_result), 64'd0);
    end
    @(posedge clk);
    #1;
    drain();

    out_ready = 1'b0;
    send(3'b000, 1, 1);
    send(3'b000, 2, 2);
    repeat (2) begin
      @(negedge clk);
      check("skid_in_ready", 64'(in_ready), 64'd0);
      check("skid_hold", 64'(alu_result), 64'd2);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("skid_first_out", 64'(alu_result), 64'd2);
    check("skid_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("skid_second_out", 64'(alu_result), 64'd4);
    check("skid_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    drain();

    c0 = cyc;
    fork
      begin
        for (int i = 0; i < 8; i++) send(3'b000, W'(i), W'(i));
      end
      begin
        @(negedge clk);
        repeat (8) begin
          @(negedge clk);
          check("stream_valid", 64'(out_valid), 64'd1);
          check("stream_ready", 64'(in_ready), 64'd1);
        end
      end
    join
    check("stream_cycles", 64'(cyc - c0), 64'd8);
    drain();

    out_ready = 1'b0;
    send(3'b000, 1, 1);
    send(3'b000, 2, 2);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    mon_en    = 1'b1;
    out_ready = 1'b1;
    send(3'b001, 10, 4);
    @(negedge clk);
    check("midrst_result", 64'(alu_result), 64'd6);
    @(posedge clk);
    #1;
    drain();
    @(negedge clk);
    check("midrst_no_stale", 64'(out_valid), 64'd0);
    check("total_out", 64'(n_out), 64'd20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_alu_stage.md
Name: exec_alu_stage

Overview:
- Registered execute stage directly downstream of the ALU decoder; consumes the 3-bit ALUControl code together with two operands.
- Computes result, Zero flag and an illegal-op flag, then presents them through a valid/ready handshake backed by a 2-entry skid buffer.
- Lets the core insert a pipeline register between decode and writeback/branch logic without combinational ready paths.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream presents a valid operation
- in_ready  output  1  stage can accept an operation this cycle
- alu_control  input  3  ALUControl code from the decoder
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- out_valid  output  1  result registers hold a valid operation
- out_ready  input  1  downstream accepts the result this cycle
- alu_result  output  WIDTH  computed result
- zero  output  1  high when alu_result == 0
- illegal_op  output  1  alu_control was an undefined code

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n sampled on the rising edge of clk).
- Reset: out_valid=0, in_ready=1, alu_result=0, zero=0, illegal_op=0; the skid entry is cleared.
- Reset mid-operation: any held or in-flight operation is discarded. The first accept after reset_n rises is the first op seen downstream.
- Encoding:
  - 000 add: a+b, modulo 2^WIDTH.
  - 001 sub: a-b, modulo 2^WIDTH.
  - 010 and.
  - 011 or.
  - 101 slt: signed two's-complement compare; result is {WIDTH-1 zeros, (a<b)}.
- Other codes (100, 110, 111, X): result=0, zero=1, illegal_op=1. X on alu_control while in_valid=1 is treated as illegal (no X propagation to outputs).
- Zero flag is computed from the result being stored, never from stale data.
- Handshake:
  - Accept occurs when in_valid & in_ready on a rising edge.
  - Transfer occurs when out_valid & out_ready.
  - Upstream must hold inputs stable while in_valid & !in_ready.
  - The stage holds outputs stable while out_valid & !out_ready.
- Latency: an accepted op appears on outputs the next cycle when the pipeline is empty. Full throughput is 1 op/cycle while out_ready=1.
- State machine (count of held ops):
  - EMPTY: out_valid=0, in_ready=1. Accept -> FULL; the main register is loaded.
  - FULL: out_valid=1, in_ready=1.
    - Accept & transfer -> FULL; the main register is reloaded.
    - Transfer only -> EMPTY.
    - Accept & !out_ready -> SKID; the new op is written to the skid register.
    - Neither -> FULL.
  - SKID: out_valid=1, in_ready=0. Transfer -> FULL; the skid register moves to the main register. No accept is possible.
- in_ready is a registered function of state only (1 in EMPTY/FULL, 0 in SKID), with no combinational path from out_ready.
- in_valid=1 with in_ready=0 has no effect.
- Outputs come directly from the main register: alu_result, zero and illegal_op are valid only while out_valid=1 and hold their last value otherwise.

Decomposition:
- Shared package alu_pkg:
  - localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - State encoding: EMPTY=2'b00, FULL=2'b01, SKID=2'b10.
  - The decoder imports the same constants.
- One sub-module, alu_core: purely combinational, (alu_control, src_a, src_b) -> (result, zero, illegal). It is instantiated once on the input side.
- The stage top holds the FSM, main register and skid register.

Test Plan:
- Reset, then single op: reset_n=0 for 2 cycles -> out_valid=0, in_ready=1. Then add 5+7 with out_ready=1 -> next cycle out_valid=1, alu_result=12, zero=0.
- Arithmetic boundaries (WIDTH=32):
  - sub 3-3 -> 0, zero=1.
  - add 0xFFFFFFFF+1 -> 0, zero=1.
  - slt 0xFFFFFFFF vs 1 -> 1.
  - slt 1 vs 0xFFFFFFFF -> 0.
  - and 0xF0F0 & 0x0FF0 -> 0x00F0.
  - or 0xF000 | 0x000F -> 0xF00F.
- Illegal codes: alu_control=3'b110 with a=9, b=4 -> alu_result=0, zero=1, illegal_op=1. Code 3'bxxx gives the same response.
- Backpressure and skid: hold out_ready=0 and issue ops A(1+1), B(2+2) -> after B, in_ready=0 and outputs hold 2. Raise out_ready -> outputs 2 then 4, in order; in_ready returns to 1 one cycle after the first transfer.
- Streaming: 8 back-to-back adds (i+i) with out_ready=1 -> 8 results 0,2,...,14 on consecutive cycles, no bubbles, in_ready constantly 1.
- Reset mid-operation: fill to SKID, then assert reset_n=0 for one cycle -> out_valid=0, in_ready=1. The next op 10-4 yields 6 with no stale result delivered.
